// File: rtl/link_frame_pkg.sv
// Shared definitions for the single-wire command link: frame geometry, FSM
// state encoding and command opcodes used by both transmitter and receiver.
package link_frame_pkg;

  localparam int LINK_FRAME_W = 32;
  localparam int LINK_CMD_W   = 8;
  localparam int LINK_DATA_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TRAIL = 2'd2,
    ST_GAP   = 2'd3
  } link_state_e;

  // Command opcodes carried in frame bits [31:24]
  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_STATUS  = 8'h10;
  localparam logic [7:0] OP_ENCODER = 8'h20;
  localparam logic [7:0] OP_FAULT   = 8'h7E;

endpackage

// File: rtl/piso_frame_tx.sv
// Serializes a {CMD, DATA} frame LSB-first on dout with a framing enable,
// one trailing enable cycle for the partner to latch, then an idle gap.
module piso_frame_tx
  import link_frame_pkg::*;
#(
  parameter int FRAME_W    = LINK_FRAME_W,
  parameter int CMD_W      = LINK_CMD_W,
  parameter int DATA_W     = LINK_DATA_W,
  parameter int GAP_CYCLES = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  CMD,
  input  logic [DATA_W-1:0] DATA,
  input  logic              start,
  output logic              busy,
  output logic              dout,
  output logic              en_piso,
  output logic              done
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam int GAP_W = 4;

  if (CMD_W + DATA_W != 32 || FRAME_W != 32) begin : g_bad_width
    $error("piso_frame_tx: CMD_W + DATA_W and FRAME_W must both equal 32");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("piso_frame_tx: GAP_CYCLES must be within 1..15");
  end

  link_state_e        state_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               dout_q;
  logic               en_q;
  logic               done_q;
  logic               busy_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      dout_q    <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shreg_q   <= {CMD, DATA};
            bit_cnt_q <= '0;
            dout_q    <= DATA[0];
            en_q      <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // dout is registered, so it takes the bit that becomes shreg[0]
          // after this shift; zero fill makes the trail bit 0 automatically.
          shreg_q   <= {1'b0, shreg_q[FRAME_W-1:1]};
          dout_q    <= shreg_q[1];
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
            state_q <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          en_q      <= 1'b0;
          dout_q    <= 1'b0;
          done_q    <= 1'b1;
          gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
          state_q   <= ST_GAP;
        end
        ST_GAP: begin
          done_q <= 1'b0;
          if (gap_cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign dout    = dout_q;
  assign en_piso = en_q;
  assign done    = done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Scoreboard bench: a bench-side receiver rebuilds frames from dout/en_piso
// and compares them against frames queued when stimulus is driven.
module tb_piso_frame_tx;
  import link_frame_pkg::*;

  localparam int GAP = 2;

  logic        sys_clk = 1'b0;
  logic        rst     = 1'b1;
  logic [7:0]  CMD     = '0;
  logic [23:0] DATA    = '0;
  logic        start   = 1'b0;
  logic        busy, dout, en_piso, done;

  piso_frame_tx #(.GAP_CYCLES(GAP)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .CMD     (CMD),
    .DATA    (DATA),
    .start   (start),
    .busy    (busy),
    .dout    (dout),
    .en_piso (en_piso),
    .done    (done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge sys_clk) cyc++;

  // Bench-side receiver
  logic        b2b = 1'b0;
  int          frames_done = 0;
  int          aborts = 0;
  int          done_cnt = 0;
  int          run = 0;
  int          low_run = 0;
  int          prev_start = 0;
  logic        have_prev = 1'b0;
  logic        en_prev = 1'b0;
  logic [31:0] frame = '0;

  always @(negedge sys_clk) begin
    if (done) done_cnt++;
    if (en_piso) begin
      if (!en_prev) begin
        if (b2b && have_prev) begin
          chk("period", 64'(cyc - prev_start), 64'(34 + GAP));
          chk("low_gap", 64'(low_run), 64'(GAP + 1));
        end
        prev_start = cyc;
        have_prev  = b2b;
      end
      if (run < 32) frame[run] = dout;
      else if (run == 32) chk("trail_dout", 64'(dout), 64'd0);
      run++;
      low_run = 0;
    end else begin
      if (en_prev) begin
        if (run == 33) begin
          chk("done_at_end", 64'(done), 64'd1);
          chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) chk("frame", 64'(frame), 64'(exp_q.pop_front()));
          frames_done++;
        end else begin
          aborts++;
        end
        run = 0;
      end
      low_run++;
    end
    en_prev = en_piso;
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("frame_timeout", 64'(frames_done >= target), 64'd1);
  endtask

  initial begin
    int f0, a0, d0, en_cnt, busy_cnt, done_k, bad;
    logic [31:0] cap;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_en", 64'(en_piso), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Single frame with cycle-accurate timing walk
    d0 = done_cnt;
    CMD = 8'hA5; DATA = 24'h123456; start = 1'b1;
    exp_q.push_back(32'hA5123456);
    en_cnt = 0; busy_cnt = 0; done_k = -1; cap = '0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge sys_clk);
      if (k == 0) begin
        start = 1'b0; CMD = 8'hFF; DATA = 24'hFFFFFF;
      end
      if (k < 32) cap[k] = dout;
      if (en_piso) en_cnt++;
      if (busy) busy_cnt++;
      if (done && done_k < 0) done_k = k;
    end
    chk("single_word", 64'(cap), 64'h00000000A5123456);
    chk("single_en_cycles", 64'(en_cnt), 64'd33);
    chk("single_done_k", 64'(done_k), 64'd33);
    chk("single_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("single_busy_cycles", 64'(busy_cnt), 64'(33 + GAP));
    wait_frames(1, 20);

    // Back-to-back frames with start held high
    repeat (3) @(negedge sys_clk);
    f0 = frames_done;
    b2b = 1'b1;
    CMD = OP_STATUS; DATA = 24'($urandom); start = 1'b1;
    exp_q.push_back({CMD, DATA});
    @(posedge sys_clk);
    for (int i = 1; i < 12; i++) begin
      @(negedge sys_clk);
      CMD  = (i % 3 == 0) ? OP_ENCODER : ((i % 3 == 1) ? OP_NOP : 8'($urandom));
      DATA = 24'($urandom);
      exp_q.push_back({CMD, DATA});
      repeat (36) @(posedge sys_clk);
    end
    @(negedge sys_clk);
    start = 1'b0;
    wait_frames(f0 + 12, 80);
    b2b = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("b2b_count", 64'(frames_done - f0), 64'd12);

    // Busy rejection
    f0 = frames_done; a0 = aborts;
    CMD = OP_FAULT; DATA = 24'h5A0F33; start = 1'b1;
    exp_q.push_back({OP_FAULT, 24'h5A0F33});
    @(negedge sys_clk);
    start = 1'b0;
    repeat (4) @(negedge sys_clk);
    CMD = 8'h01; DATA = 24'h0; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_frames(f0 + 1, 60);
    repeat (60) @(negedge sys_clk);
    chk("reject_frames", 64'(frames_done - f0), 64'd1);
    chk("reject_aborts", 64'(aborts - a0), 64'd0);

    // Reset mid-frame at bit 17
    f0 = frames_done; a0 = aborts;
    CMD = 8'h3C; DATA = 24'hABCDEF; start = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(negedge sys_clk);
      if (k == 0) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_en", 64'(en_piso), 64'd0);
    chk("midrst_dout", 64'(dout), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge sys_clk);
    chk("midrst_aborts", 64'(aborts - a0), 64'd1);
    chk("midrst_frames", 64'(frames_done - f0), 64'd0);
    CMD = 8'hC3; DATA = 24'h00FF00; start = 1'b1;
    exp_q.push_back({8'hC3, 24'h00FF00});
    @(negedge sys_clk);
    start = 1'b0;
    wait_frames(f0 + 1, 60);

    // Simultaneous rst and start
    repeat (5) @(negedge sys_clk);
    f0 = frames_done; bad = 0;
    CMD = 8'h99; DATA = 24'h111111; rst = 1'b1; start = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (busy || en_piso) bad++;
      @(negedge sys_clk);
    end
    chk("rststart_idle", 64'(bad), 64'd0);
    chk("rststart_frames", 64'(frames_done - f0), 64'd0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
